sync_fifo_bram: RTL and testbench

- Single-clock first-word-fall-through FIFO whose storage is a simple-dual-port synchronous RAM, so that synthesis maps it to block RAM.
- Sits between a producer stream and a consumer stream, each with a valid/ready handshake.
- It is the read-side companion to our inferred block-RAM tests: it owns write enable, read address and read register, and it drains stored words in order.
- All outputs are registered or derived from registered state only.

---
 rtl/sync_fifo_bram_if.sv | 34 +++
 rtl/sync_fifo_bram_bram.sv | 30 +++
 rtl/sync_fifo_bram.sv | 87 ++++++++
 tb/tb_sync_fifo_bram.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_bram_if.sv
// Producer/consumer handshake bundle for sync_fifo_bram.
// The FIFO takes the slave view; the stream endpoints drive through the master view.
interface sync_fifo_bram_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
);
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDRESS_WIDTH:0] level;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  level
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output level
    );
endinterface

// File: rtl/sync_fifo_bram_bram.sv
// Simple-dual-port synchronous RAM with a read-enabled output register.
// Written in the plain form synthesis recognises as block RAM; rdata has no reset.
module bram_sdp_re #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);
    localparam int DEPTH = 2**ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/sync_fifo_bram.sv
// First-word-fall-through FIFO built around bram_sdp_re; the RAM read register is the output stage.
// Pointers, counters, out_valid and level live here; out_data is forced to 0 until the first read after reset.
module sync_fifo_bram #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_fifo_bram_if.slave   bus
);
    localparam int                     DEPTH     = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT = (ADDRESS_WIDTH+1)'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_WIDTH:0]   ram_count_q, ram_count_d;
    logic [ADDRESS_WIDTH:0]   level_q, level_d;
    logic                     out_valid_q, out_valid_d;
    logic                     in_ready_q, in_ready_d;
    logic                     loaded_q, loaded_d;

    logic                     push;
    logic                     rd_en;
    logic [DATA_WIDTH-1:0]    ram_rdata;

    // A read is issued only from registered ram_count, so it never targets a word written this edge.
    always_comb begin
        push        = bus.in_valid & in_ready_q;
        rd_en       = (ram_count_q != '0) & (~out_valid_q | bus.out_ready);

        wr_ptr_d    = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ram_count_d = ram_count_q
                    + {{ADDRESS_WIDTH{1'b0}}, push}
                    - {{ADDRESS_WIDTH{1'b0}}, rd_en};

        if (rd_en) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        level_d    = ram_count_d + {{ADDRESS_WIDTH{1'b0}}, out_valid_d};
        in_ready_d = (level_d < DEPTH_CNT);
        loaded_d   = loaded_q | rd_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            loaded_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            loaded_q    <= loaded_d;
        end
    end

    bram_sdp_re #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (bus.in_data),
        .re    (rd_en),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign bus.out_data  = loaded_q ? ram_rdata : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.level     = level_q;
endmodule

// File: tb/tb_sync_fifo_bram.sv
// Randomised and directed bench for sync_fifo_bram, checked every cycle against a queue model.
// The model tracks held words with their push edge; the head is visible once it is older than the last edge.
module tb_sync_fifo_bram;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 2**AW;

    typedef struct {
        logic [DW-1:0] data;
        int            t;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n;

    sync_fifo_bram_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    sync_fifo_bram #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    entry_t        mq[$];
    int            cyc        = 0;
    bit            model_init = 0;
    bit            vis        = 0;
    bit            zero_exp   = 0;
    bit            hold       = 0;
    logic [DW-1:0] last_data  = '0;
    logic [DW-1:0] got[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Model update: every edge, decide pop/push from the inputs and the model's own visibility.
    initial begin
        bit pop, psh;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                mq.delete();
                model_init = 1;
                zero_exp   = 1;
                hold       = 0;
            end else if (model_init) begin
                pop  = bus.out_ready && vis;
                psh  = bus.in_valid && (mq.size() < DEPTH);
                hold = vis && !bus.out_ready;
                if (pop) void'(mq.pop_front());
                if (psh) mq.push_back('{bus.in_data, cyc});
            end
            vis = model_init && (mq.size() > 0) && (mq[0].t < cyc);
            if (vis) zero_exp = 0;
        end
    end

    // Compare process on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_init) begin
                check_output("in_ready",  bus.in_ready,  (mq.size() < DEPTH) ? 1 : 0);
                check_output("level",     bus.level,     mq.size());
                check_output("out_valid", bus.out_valid, vis);
                if (vis)
                    check_output("out_data", bus.out_data, mq[0].data);
                else if (zero_exp)
                    check_output("out_data_zero", bus.out_data, 0);
                if (hold && vis)
                    check_output("out_data_stable", bus.out_data, last_data);
            end
            last_data = bus.out_data;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input bit v, input logic [DW-1:0] d, input bit r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply_stimulus(0, '0, 0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_words(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1, first + DW'(i), 0);
            tick();
        end
        apply_stimulus(0, '0, 0);
    endtask

    task automatic drain(input int budget);
        got.delete();
        bus.in_valid  = 0;
        bus.out_ready = 1;
        for (int c = 0; c < budget; c++) begin
            if (bus.out_valid) got.push_back(bus.out_data);
            tick();
            if (bus.level == 0 && !bus.out_valid) break;
        end
        check_output("drain_done", bus.level, 0);
        bus.out_ready = 0;
    endtask

    initial begin
        int idx, max_lvl, gaps;
        bit started, accepted;
        logic [DW-1:0] exp4[4];

        rst_n = 1'b1;
        apply_stimulus(0, '0, 0);
        tick();
        do_reset();
        tick();

        $display("[TB] test 1: reset then single word");
        check_output("t1_rst_valid", bus.out_valid, 0);
        check_output("t1_rst_data",  bus.out_data,  0);
        check_output("t1_rst_level", bus.level,     0);
        check_output("t1_rst_ready", bus.in_ready,  1);
        apply_stimulus(1, 8'hA5, 0);
        tick();
        apply_stimulus(0, '0, 0);
        check_output("t1_level_e1", bus.level,     1);
        check_output("t1_valid_e1", bus.out_valid, 0);
        tick();
        check_output("t1_valid_e2", bus.out_valid, 1);
        check_output("t1_data_e2",  bus.out_data,  8'hA5);
        tick();
        tick();
        check_output("t1_hold", bus.out_data, 8'hA5);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        check_output("t1_pop_valid", bus.out_valid, 0);
        check_output("t1_pop_level", bus.level,     0);

        $display("[TB] test 2: fill to full");
        push_words(8'h01, 4);
        check_output("t2_full_level", bus.level,    4);
        check_output("t2_full_ready", bus.in_ready, 0);
        apply_stimulus(1, 8'h05, 0);
        tick();
        apply_stimulus(0, '0, 0);
        check_output("t2_reject_level", bus.level, 4);
        drain(20);
        check_output("t2_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check_output("t2_order", got[i], 8'h01 + DW'(i));

        $display("[TB] test 3: wrap-around streaming");
        got.delete();
        idx = 0; max_lvl = 0; gaps = 0; started = 0;
        bus.out_ready = 1;
        for (int c = 0; c < 80 && got.size() < 20; c++) begin
            bus.in_valid = (idx < 20);
            bus.in_data  = 8'h10 + idx[7:0];
            accepted     = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                got.push_back(bus.out_data);
                started = 1;
            end else if (started) begin
                gaps++;
            end
            tick();
            if (accepted) idx++;
            if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
        end
        apply_stimulus(0, '0, 0);
        check_output("t3_count",   got.size(), 20);
        check_output("t3_gaps",    gaps,       0);
        check_output("t3_max_lvl", (max_lvl <= 2) ? 1 : 0, 1);
        for (int i = 0; i < got.size(); i++)
            check_output("t3_order", got[i], 8'h10 + DW'(i));
        tick();
        tick();
        check_output("t3_empty", bus.level, 0);

        $display("[TB] test 4: full plus simultaneous pop");
        push_words(8'h31, 4);
        check_output("t4_level4", bus.level, 4);
        apply_stimulus(1, 8'h55, 1);
        check_output("t4_ready0", bus.in_ready, 0);
        tick();
        check_output("t4_level3", bus.level,    3);
        check_output("t4_ready1", bus.in_ready, 1);
        bus.out_ready = 0;
        tick();
        apply_stimulus(0, '0, 0);
        check_output("t4_level4b", bus.level, 4);
        drain(20);
        exp4 = '{8'h32, 8'h33, 8'h34, 8'h55};
        check_output("t4_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check_output("t4_order", got[i], exp4[i]);

        $display("[TB] test 5: random backpressure");
        push_words(8'hC0, 2);
        for (int c = 0; c < 50; c++) begin
            apply_stimulus($urandom_range(0, 1), DW'($urandom), $urandom_range(0, 1));
            tick();
        end
        drain(40);

        $display("[TB] test 6: reset mid-operation");
        push_words(8'hE0, 3);
        tick();
        check_output("t6_level3", bus.level, 3);
        do_reset();
        check_output("t6_valid", bus.out_valid, 0);
        check_output("t6_data",  bus.out_data,  0);
        check_output("t6_level", bus.level,     0);
        check_output("t6_ready", bus.in_ready,  1);
        apply_stimulus(1, 8'h77, 0);
        tick();
        apply_stimulus(0, '0, 1);
        started = 0;
        for (int c = 0; c < 10 && !started; c++) begin
            if (bus.out_valid) started = 1;
            else tick();
        end
        check_output("t6_seen", started, 1);
        check_output("t6_first", bus.out_data, 8'h77);
        tick();
        bus.out_ready = 0;
        tick();
        check_output("t6_empty", bus.level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
